// File: rtl/slip_escaper_pipe.sv
// SLIP byte-stuffing encoder with a registered output stage, optional idle keepalive
// (IDLE_CYCLES) and an optional leading END per frame (`SLIP_ESCAPER_PIPE_LEAD_END_EN).
module slip_escaper_pipe #(
  parameter int unsigned                SYMBOL_WIDTH   = 8,
  parameter logic [SYMBOL_WIDTH-1:0]    SYMBOL_END     = 8'hC0,
  parameter logic [SYMBOL_WIDTH-1:0]    SYMBOL_ESC     = 8'hDB,
  parameter logic [SYMBOL_WIDTH-1:0]    SYMBOL_ESC_END = 8'hDC,
  parameter logic [SYMBOL_WIDTH-1:0]    SYMBOL_ESC_ESC = 8'hDD,
  parameter int unsigned                IDLE_CYCLES    = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [SYMBOL_WIDTH-1:0] i_data,
  input  logic                    i_end,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [SYMBOL_WIDTH-1:0] o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_in_frame
);

  localparam bit          KA_EN   = (IDLE_CYCLES != 0);
  localparam logic [15:0] KA_LAST = KA_EN ? 16'(IDLE_CYCLES - 1) : 16'd0;

`ifdef SLIP_ESCAPER_PIPE_LEAD_END_EN
  typedef enum logic [1:0] {NORMAL, HOLD, SEND_ESC_END, SEND_ESC_ESC} state_t;
`else
  typedef enum logic [1:0] {NORMAL, SEND_ESC_END, SEND_ESC_ESC} state_t;
`endif

  state_t                  state_q, state_d;
  state_t                  route_state;
  logic [SYMBOL_WIDTH-1:0] route_in, route_sym;
  logic [SYMBOL_WIDTH-1:0] load_data;
  logic                    load;
  logic                    out_free;
  logic                    accept;
  logic                    in_frame_d;
  logic                    rdy_en_q;
  logic [15:0]             idle_cnt_q, idle_cnt_d;
`ifdef SLIP_ESCAPER_PIPE_LEAD_END_EN
  logic [SYMBOL_WIDTH-1:0] hold_q, hold_d;
`endif

  // Escape routing is shared by the direct path and the HOLD replay path.
  always_comb begin
`ifdef SLIP_ESCAPER_PIPE_LEAD_END_EN
    route_in = (state_q == HOLD) ? hold_q : i_data;
`else
    route_in = i_data;
`endif
    route_sym   = route_in;
    route_state = NORMAL;
    if (route_in == SYMBOL_END) begin
      route_sym   = SYMBOL_ESC;
      route_state = SEND_ESC_END;
    end else if (route_in == SYMBOL_ESC) begin
      route_sym   = SYMBOL_ESC;
      route_state = SEND_ESC_ESC;
    end
  end

  assign out_free = !o_valid || i_ready;
  // rdy_en_q keeps o_ready low through reset and the first edge after it.
  assign o_ready  = rdy_en_q && (state_q == NORMAL) && out_free;
  assign accept   = i_valid && o_ready;

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_data  = o_data;
    in_frame_d = o_in_frame;
    idle_cnt_d = '0;
`ifdef SLIP_ESCAPER_PIPE_LEAD_END_EN
    hold_d     = hold_q;
`endif
    case (state_q)
      NORMAL: begin
        if (accept) begin
          load = 1'b1;
          if (i_end) begin
            load_data  = SYMBOL_END;
            in_frame_d = 1'b0;
          end else begin
            in_frame_d = 1'b1;
`ifdef SLIP_ESCAPER_PIPE_LEAD_END_EN
            if (!o_in_frame) begin
              load_data = SYMBOL_END;
              hold_d    = i_data;
              state_d   = HOLD;
            end else begin
              load_data = route_sym;
              state_d   = route_state;
            end
`else
            load_data = route_sym;
            state_d   = route_state;
`endif
          end
        end else if (KA_EN && !o_in_frame && !i_valid && !o_valid) begin
          if (idle_cnt_q == KA_LAST) begin
            load      = 1'b1;
            load_data = SYMBOL_END;
          end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
        end
      end
`ifdef SLIP_ESCAPER_PIPE_LEAD_END_EN
      HOLD: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = route_sym;
          state_d   = route_state;
        end
      end
`endif
      SEND_ESC_END: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = SYMBOL_ESC_END;
          state_d   = NORMAL;
        end
      end
      SEND_ESC_ESC: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = SYMBOL_ESC_ESC;
          state_d   = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= NORMAL;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_in_frame <= 1'b0;
      idle_cnt_q <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      o_in_frame <= in_frame_d;
      idle_cnt_q <= idle_cnt_d;
      rdy_en_q   <= 1'b1;
      if (load) begin
        o_data  <= load_data;
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef SLIP_ESCAPER_PIPE_LEAD_END_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) hold_q <= '0;
    else          hold_q <= hold_d;
  end
`endif

endmodule

// File: tb/tb_slip_escaper_pipe.sv
// Scoreboard bench for slip_escaper_pipe: DUT A (no keepalive) for framing/escaping,
// DUT B (IDLE_CYCLES=4) for keepalive behaviour.
module tb_slip_escaper_pipe;

`ifdef SLIP_ESCAPER_PIPE_LEAD_END_EN
  localparam bit LEAD = 1'b1;
`else
  localparam bit LEAD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, a_valid, a_end, a_ready, a_ovalid, a_iready, a_in_frame;
  logic [7:0] a_data, a_odata;
  logic       rst_b, b_valid, b_end, b_ready, b_ovalid, b_iready, b_in_frame;
  logic [7:0] b_data, b_odata;

  slip_escaper_pipe #(.SYMBOL_WIDTH(8), .IDLE_CYCLES(0)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_data(a_data), .i_end(a_end), .i_valid(a_valid),
    .o_ready(a_ready), .o_data(a_odata), .o_valid(a_ovalid), .i_ready(a_iready),
    .o_in_frame(a_in_frame));

  slip_escaper_pipe #(.SYMBOL_WIDTH(8), .IDLE_CYCLES(4)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .i_data(b_data), .i_end(b_end), .i_valid(b_valid),
    .o_ready(b_ready), .o_data(b_odata), .o_valid(b_ovalid), .i_ready(b_iready),
    .o_in_frame(b_in_frame));

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  bit         m_in_frame;
  bit         rand_on;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference encoding of one accepted input, straight from the SLIP rules.
  task automatic model_push(input logic [7:0] d, input logic e);
    if (e) begin
      exp_q.push_back(8'hC0);
      m_in_frame = 1'b0;
    end else begin
      if (LEAD && !m_in_frame) exp_q.push_back(8'hC0);
      if (d == 8'hC0) begin
        exp_q.push_back(8'hDB); exp_q.push_back(8'hDC);
      end else if (d == 8'hDB) begin
        exp_q.push_back(8'hDB); exp_q.push_back(8'hDD);
      end else begin
        exp_q.push_back(d);
      end
      m_in_frame = 1'b1;
    end
  endtask

  task automatic monitor_a();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_a) begin
        exp_q.delete();
        m_in_frame = 1'b0;
      end else begin
        if (a_ovalid && a_iready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", {24'd0, a_odata}, 32'h100);
          end else begin
            e = exp_q.pop_front();
            chk("out_symbol", {24'd0, a_odata}, {24'd0, e});
          end
        end
        if (a_valid && a_ready) model_push(a_data, a_end);
      end
    end
  endtask

  task automatic ready_noise();
    forever begin
      @(posedge clk);
      if (rand_on) begin
        #1;
        a_iready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic e, output int waits);
    a_valid = 1'b1; a_data = d; a_end = e; waits = 0;
    @(negedge clk);
    while (!a_ready && waits < 1000) begin
      waits++;
      @(negedge clk);
    end
    if (!a_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: actual=no_ready required=ready at %0t", $time);
    end
    @(posedge clk); #1;
    a_valid = 1'b0; a_end = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int         w, n, last, cyc;
    logic [7:0] bq[$];
    logic [7:0] bexp[$];
    rst_a = 0; a_valid = 0; a_end = 0; a_data = 0; a_iready = 1; rand_on = 0;
    rst_b = 0; b_valid = 0; b_end = 0; b_data = 0; b_iready = 1;
    m_in_frame = 0;
    fork
      monitor_a();
      ready_noise();
    join_none
    #1;
    chk("rst_o_valid", {31'd0, a_ovalid}, 0);
    chk("rst_o_data", {24'd0, a_odata}, 0);
    chk("rst_in_frame", {31'd0, a_in_frame}, 0);
    chk("rst_o_ready", {31'd0, a_ready}, 0);
    cycles(3);
    chk("rst_o_ready_held", {31'd0, a_ready}, 0);

    // Keepalive on DUT B: END every 4 idle cycles (plus the output cycle).
    rst_b = 1;
    n = 0; last = -1;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (b_ovalid) begin
        chk("ka_symbol", {24'd0, b_odata}, 32'hC0);
        if (last >= 0) chk("ka_gap", last >= 0 ? cyc - last : 0, 5);
        last = cyc; n++;
      end
    end
    chk("ka_count", {31'd0, n >= 6}, 1);
    @(posedge clk); #1;
    b_valid = 1; b_data = 8'h22; b_end = 0; w = 0;
    @(negedge clk);
    while (!b_ready && w < 100) begin w++; @(negedge clk); end
    chk("b_accept", {31'd0, b_ready}, 1);
    @(posedge clk); #1;
    b_valid = 0;
    if (LEAD) bexp.push_back(8'hC0);
    bexp.push_back(8'h22);
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (b_ovalid) bq.push_back(b_odata);
    end
    chk("ka_in_frame_count", bq.size(), bexp.size());
    for (int i = 0; i < bq.size() && i < bexp.size(); i++)
      chk("ka_frame_symbol", {24'd0, bq[i]}, {24'd0, bexp[i]});
    chk("b_in_frame", {31'd0, b_in_frame}, 1);

    // DUT A out of reset: ready only from the first edge onward.
    @(posedge clk); #1;
    rst_a = 1;
    #1 chk("ready_after_deassert", {31'd0, a_ready}, 0);
    cycles(1);
    chk("ready_first_edge", {31'd0, a_ready}, 1);

    // Basic escaping, o_ready drop for one cycle after each escape.
    send_a(8'h11, 0, w);
    send_a(8'hC0, 0, w);
    chk("esc_end_ready_low", {31'd0, a_ready}, 0);
    cycles(1);
    chk("esc_end_ready_back", {31'd0, a_ready}, 1);
    send_a(8'hDB, 0, w);
    chk("esc_esc_ready_low", {31'd0, a_ready}, 0);
    cycles(1);
    chk("esc_esc_ready_back", {31'd0, a_ready}, 1);
    send_a(8'h5A, 1, w);
    cycles(3);

    // Throughput inside a frame.
    send_a(8'h20, 0, w);
    cycles(2);
    for (int i = 0; i < 3; i++) begin
      send_a(8'h21 + 8'(i), 0, w);
      chk("throughput_waits", w, 0);
    end
    cycles(3);

    // Output stall: data held stable, nothing lost after release.
    a_iready = 0;
    send_a(8'h11, 0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, a_ovalid}, 1);
      chk("stall_data", {24'd0, a_odata}, 32'h11);
      chk("stall_ready", {31'd0, a_ready}, 0);
    end
    @(posedge clk); #1;
    a_iready = 1;
    send_a(8'h00, 1, w);
    cycles(3);

    // Reset while the second escape symbol is pending.
    send_a(8'h12, 0, w);
    cycles(3);
    a_iready = 0;
    send_a(8'hC0, 0, w);
    #1 rst_a = 0;
    #1;
    chk("midrst_valid", {31'd0, a_ovalid}, 0);
    chk("midrst_in_frame", {31'd0, a_in_frame}, 0);
    chk("midrst_ready", {31'd0, a_ready}, 0);
    cycles(2);
    rst_a = 1; a_iready = 1;
    cycles(2);
    send_a(8'h44, 0, w);
    send_a(8'h00, 1, w);
    cycles(4);
    chk("midrst_drained", exp_q.size(), 0);

    // Random traffic, 50% valid / 50% ready.
    rand_on = 1;
    for (int i = 0; i < 10000; i++) begin
      logic [7:0] d;
      logic       e;
      int         r;
      r = $urandom_range(0, 9);
      d = 8'($urandom_range(0, 255));
      e = (r == 2);
      if (r == 0) d = 8'hC0;
      if (r == 1) d = 8'hDB;
      if ($urandom_range(0, 1) == 1) cycles(1);
      send_a(d, e, w);
    end
    rand_on = 0;
    @(posedge clk); #2;
    a_iready = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    cycles(2);
    chk("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slip_escaper_pipe.md
SLIP_ESCAPER_PIPE -- requirements
Module: slip_escaper_pipe

Interface
REQ-001 The block SHALL have parameter SYMBOL_WIDTH, default 8: bit width of every symbol.
REQ-002 The block SHALL have parameters SYMBOL_END, SYMBOL_ESC, SYMBOL_ESC_END and SYMBOL_ESC_ESC, defaults 8'hC0, 8'hDB, 8'hDC and 8'hDD: the four SLIP symbols, all distinct.
REQ-003 The block SHALL have parameter IDLE_CYCLES, default 0: idle keepalive interval in cycles, where 0 disables keepalive; legal range is 0 or 2..2^16-1.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port i_data, input, SYMBOL_WIDTH bits: input symbol.
REQ-007 The block SHALL have port i_end, input, 1 bit: end marker; i_data is ignored when i_end is 1.
REQ-008 The block SHALL have ports i_valid (input, 1 bit) and o_ready (output, 1 bit): input stream handshake.
REQ-009 The block SHALL have ports o_data (output, SYMBOL_WIDTH bits) and o_valid (output, 1 bit): output symbol and valid, both registered.
REQ-010 The block SHALL have port i_ready, input, 1 bit: output stream ready.
REQ-011 The block SHALL have port o_in_frame, output, 1 bit: registered flag, 1 after a data symbol has been accepted and before the next end marker has been accepted.

Function
REQ-012 A transfer SHALL occur on a cycle when valid and ready are both 1; o_valid and o_data SHALL stay stable while o_valid=1 and i_ready=0.
REQ-013 Output register "free" SHALL mean o_valid=0 or i_ready=1.
REQ-014 The routing FSM SHALL have states NORMAL, HOLD, SEND_ESC_END and SEND_ESC_ESC.
REQ-015 o_ready SHALL be 1 only in state NORMAL with the output register free; otherwise 0.
REQ-016 In NORMAL, an accepted end marker SHALL load SYMBOL_END and clear o_in_frame.
REQ-017 In NORMAL, an accepted data symbol equal to SYMBOL_END SHALL load SYMBOL_ESC and move to SEND_ESC_END.
REQ-018 In NORMAL, an accepted data symbol equal to SYMBOL_ESC SHALL load SYMBOL_ESC and move to SEND_ESC_ESC.
REQ-019 In NORMAL, any other accepted data symbol SHALL be loaded unchanged.
REQ-020 Every accepted data symbol SHALL set o_in_frame.
REQ-021 An accepted symbol SHALL appear on o_data with o_valid=1 on the following cycle (latency 1).
REQ-022 Throughput SHALL be 1 symbol/cycle for non-escaped symbols while i_ready=1.
REQ-023 In SEND_ESC_END or SEND_ESC_ESC, when the output register is free, the block SHALL load SYMBOL_ESC_END or SYMBOL_ESC_ESC respectively and return to NORMAL.
REQ-024 HOLD SHALL be used only when REQ-034 is compiled in: when the output register is free, the held symbol SHALL be processed per REQ-017..REQ-019 without asserting o_ready.
REQ-025 Keepalive SHALL apply only when IDLE_CYCLES>0: a 16-bit idle counter SHALL increment on each cycle with o_in_frame=0, state NORMAL, i_valid=0 and o_valid=0, and SHALL clear on any other cycle.
REQ-026 When the idle counter reaches IDLE_CYCLES-1, the block SHALL load SYMBOL_END as a keepalive, clear the counter, and leave o_in_frame at 0.
REQ-027 If i_valid=1 on the cycle the keepalive threshold would be reached, input SHALL win: no keepalive is loaded and the counter clears.
REQ-028 Keepalive SHALL never be emitted while o_in_frame=1.

Reset
REQ-029 While i_rst_n=0, the block SHALL asynchronously force state NORMAL, o_valid=0, o_data=0, o_in_frame=0, idle counter 0 and hold register 0.
REQ-030 o_ready SHALL be 0 during reset.
REQ-031 The first transfer after reset deassertion SHALL be possible on the second rising edge after deassertion.
REQ-032 Reset mid-escape SHALL drop the pending second escape symbol with no partial output afterwards.

Configuration
REQ-033 The macro SLIP_ESCAPER_PIPE_LEAD_END_EN SHALL control the leading-END feature.
REQ-034 With SLIP_ESCAPER_PIPE_LEAD_END_EN defined, a data symbol accepted with o_in_frame=0 SHALL load SYMBOL_END, store the symbol in the hold register and move to HOLD, so every frame is preceded by SYMBOL_END.
REQ-035 Without SLIP_ESCAPER_PIPE_LEAD_END_EN, HOLD and the hold register SHALL be absent and the first symbol of a frame SHALL be processed directly per REQ-017..REQ-019.

Verification
REQ-036 The bench SHALL cover: macro off, i_ready=1, input 0x11, 0xC0, 0xDB, end -> output 0x11, 0xDB, 0xDC, 0xDB, 0xDD, 0xC0; o_ready low 1 cycle after each escape.
REQ-037 The bench SHALL cover: i_ready held 0 for 5 cycles with 0x11 loaded -> o_data=0x11 stable, o_valid=1, o_ready=0; no loss or duplication after release.
REQ-038 The bench SHALL cover: IDLE_CYCLES=4, no input after reset -> SYMBOL_END 0xC0 every 4 idle cycles; with a frame open (0x22 sent, no end) -> no keepalive.
REQ-039 The bench SHALL cover: macro on, input 0xDB, end, 0x33, end -> output 0xC0, 0xDB, 0xDD, 0xC0, 0xC0, 0x33, 0xC0.
REQ-040 The bench SHALL cover: i_rst_n pulsed low while in SEND_ESC_END -> o_valid=0 immediately, o_in_frame=0, and the next input 0x44 emitted alone.
REQ-041 The bench SHALL cover: random i_valid/i_ready at 50% over 10000 symbols -> unescaped output equals input, and 0xC0 appears only for end markers and keepalives.
